// File: rtl/axilite_ctrl_master_if.sv
// Bundle of the command/response interface and the AXI4-Lite master bus
// used by axilite_ctrl_master. The master modport is the controller side,
// the slave modport is the side that issues commands and models the
// register slave.
//
// Handshake rule for every valid/ready pair below (cmd, rsp, aw, w, b, ar, r):
// a transfer happens on a rising clk edge where valid && ready are both 1;
// once valid is raised it stays high with a stable payload until that
// transfer, and ready may change freely without depending on valid.
interface axilite_ctrl_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Command / response side
  logic                      i_cmd_valid;
  logic                      o_cmd_ready;
  logic                      i_cmd_write;
  logic [ADDR_WIDTH-1:0]     i_cmd_addr;
  logic [DATA_WIDTH-1:0]     i_cmd_wdata;
  logic [DATA_WIDTH/8-1:0]   i_cmd_wstrb;
  logic                      o_rsp_valid;
  logic                      i_rsp_ready;
  logic                      o_rsp_write;
  logic [DATA_WIDTH-1:0]     o_rsp_rdata;
  logic [1:0]                o_rsp_resp;
  logic                      o_rsp_timeout;

  // AXI4-Lite master side
  logic [ADDR_WIDTH-1:0]     m_axi_awaddr;
  logic [2:0]                m_axi_awprot;
  logic                      m_axi_awvalid;
  logic                      m_axi_awready;
  logic [DATA_WIDTH-1:0]     m_axi_wdata;
  logic [DATA_WIDTH/8-1:0]   m_axi_wstrb;
  logic                      m_axi_wvalid;
  logic                      m_axi_wready;
  logic [1:0]                m_axi_bresp;
  logic                      m_axi_bvalid;
  logic                      m_axi_bready;
  logic [ADDR_WIDTH-1:0]     m_axi_araddr;
  logic [2:0]                m_axi_arprot;
  logic                      m_axi_arvalid;
  logic                      m_axi_arready;
  logic [DATA_WIDTH-1:0]     m_axi_rdata;
  logic [1:0]                m_axi_rresp;
  logic                      m_axi_rvalid;
  logic                      m_axi_rready;

  modport master (
    input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_cmd_wstrb, i_rsp_ready,
    output o_cmd_ready, o_rsp_valid, o_rsp_write, o_rsp_rdata, o_rsp_resp, o_rsp_timeout,
    output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_cmd_wstrb, i_rsp_ready,
    input  o_cmd_ready, o_rsp_valid, o_rsp_write, o_rsp_rdata, o_rsp_resp, o_rsp_timeout,
    input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/axilite_ctrl_master.sv
// AXI4-Lite master for control-register access. Takes one command at a time,
// runs the AW/W/B or AR/R exchange, and returns a single response. A per-
// transaction timeout produces a SLVERR response; the late B/R of a timed-out
// transaction is then drained and discarded before a new command is taken.
// DATA_WIDTH is expected to be 32 or 64.
module axilite_ctrl_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  axilite_ctrl_master_if.master bus,
  output logic [2:0]            o_dbg_state
);

  localparam int              STRB_W    = DATA_WIDTH / 8;
  localparam logic [15:0]     TMO_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [1:0]      RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_RESP = 3'd4,
    S_RSP     = 3'd5,
    S_DRAIN   = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]       wstrb_q;
  logic                    write_q;
  // Pending flags: the channel valid is exactly the pending flag, so a valid
  // can only fall through its own handshake, whatever the FSM does.
  logic                    aw_pend_q, w_pend_q, ar_pend_q;
  logic [15:0]             tmo_cnt_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [1:0]              rsp_resp_q;
  logic                    rsp_to_q;

  logic cmd_fire, aw_fire, w_fire, ar_fire, b_fire, r_fire;
  logic busy, expire;
  logic ld_b, ld_r, ld_to;

  // Bus-facing outputs derived from registered state only
  always_comb begin
    bus.o_cmd_ready   = (state_q == S_IDLE) && !reset;
    bus.o_rsp_valid   = (state_q == S_RSP);
    bus.o_rsp_write   = write_q;
    bus.o_rsp_rdata   = rsp_rdata_q;
    bus.o_rsp_resp    = rsp_resp_q;
    bus.o_rsp_timeout = rsp_to_q;
    bus.m_axi_awaddr  = addr_q;
    bus.m_axi_awprot  = 3'b000;
    bus.m_axi_awvalid = aw_pend_q;
    bus.m_axi_wdata   = wdata_q;
    bus.m_axi_wstrb   = wstrb_q;
    bus.m_axi_wvalid  = w_pend_q;
    bus.m_axi_bready  = (state_q == S_WR_RESP) || ((state_q == S_DRAIN) && write_q);
    bus.m_axi_araddr  = addr_q;
    bus.m_axi_arprot  = 3'b000;
    bus.m_axi_arvalid = ar_pend_q;
    bus.m_axi_rready  = (state_q == S_RD_RESP) || ((state_q == S_DRAIN) && !write_q);
    o_dbg_state       = state_q;
  end

  // Handshake strobes and timeout expiry
  always_comb begin
    cmd_fire = bus.i_cmd_valid && bus.o_cmd_ready;
    aw_fire  = aw_pend_q && bus.m_axi_awready;
    w_fire   = w_pend_q && bus.m_axi_wready;
    ar_fire  = ar_pend_q && bus.m_axi_arready;
    b_fire   = bus.m_axi_bvalid && bus.m_axi_bready;
    r_fire   = bus.m_axi_rvalid && bus.m_axi_rready;
    busy     = (state_q == S_WR_REQ) || (state_q == S_WR_RESP) ||
               (state_q == S_RD_REQ) || (state_q == S_RD_RESP);
    expire   = (TIMEOUT_CYCLES != 0) && busy && (tmo_cnt_q == TMO_LIMIT);
  end

  // Next-state logic and response-load selects; a B/R handshake beats expiry
  always_comb begin
    state_d = state_q;
    ld_b    = 1'b0;
    ld_r    = 1'b0;
    ld_to   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) state_d = bus.i_cmd_write ? S_WR_REQ : S_RD_REQ;
      end
      S_WR_REQ: begin
        if (expire) begin
          ld_to   = 1'b1;
          state_d = S_RSP;
        end else if ((!aw_pend_q || aw_fire) && (!w_pend_q || w_fire)) begin
          state_d = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (b_fire) begin
          ld_b    = 1'b1;
          state_d = S_RSP;
        end else if (expire) begin
          ld_to   = 1'b1;
          state_d = S_RSP;
        end
      end
      S_RD_REQ: begin
        if (expire) begin
          ld_to   = 1'b1;
          state_d = S_RSP;
        end else if (ar_fire) begin
          state_d = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        if (r_fire) begin
          ld_r    = 1'b1;
          state_d = S_RSP;
        end else if (expire) begin
          ld_to   = 1'b1;
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (bus.i_rsp_ready) state_d = rsp_to_q ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (write_q ? b_fire : r_fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Command payload capture on acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      write_q <= 1'b0;
    end else if (cmd_fire) begin
      addr_q  <= bus.i_cmd_addr;
      wdata_q <= bus.i_cmd_wdata;
      wstrb_q <= bus.i_cmd_wstrb;
      write_q <= bus.i_cmd_write;
    end
  end

  // Per-channel pending flags: set on acceptance, cleared by own handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      ar_pend_q <= 1'b0;
    end else if (cmd_fire) begin
      aw_pend_q <= bus.i_cmd_write;
      w_pend_q  <= bus.i_cmd_write;
      ar_pend_q <= !bus.i_cmd_write;
    end else begin
      if (aw_fire) aw_pend_q <= 1'b0;
      if (w_fire)  w_pend_q  <= 1'b0;
      if (ar_fire) ar_pend_q <= 1'b0;
    end
  end

  // Timeout counter: cleared on acceptance, counts while a transaction is live
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         tmo_cnt_q <= '0;
    else if (cmd_fire) tmo_cnt_q <= '0;
    else if (busy)     tmo_cnt_q <= tmo_cnt_q + 16'd1;
  end

  // Response payload: B, R or synthesized timeout error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      rsp_to_q    <= 1'b0;
    end else if (ld_b) begin
      rsp_rdata_q <= '0;
      rsp_resp_q  <= bus.m_axi_bresp;
      rsp_to_q    <= 1'b0;
    end else if (ld_r) begin
      rsp_rdata_q <= bus.m_axi_rdata;
      rsp_resp_q  <= bus.m_axi_rresp;
      rsp_to_q    <= 1'b0;
    end else if (ld_to) begin
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_SLVERR;
      rsp_to_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axilite_ctrl_master.sv
// Directed bench for axilite_ctrl_master: zero-wait write, skewed AW/W write,
// delayed read with error response, held-off response, read timeout with
// drain, and reset in the middle of a write.
module tb_axilite_ctrl_master;

  localparam int AW = 32;
  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] dbg_state;
  int         checks = 0;
  int         errors = 0;

  // Clock
  always #5 clk = ~clk;

  axilite_ctrl_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  axilite_ctrl_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus_if),
    .o_dbg_state(dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_if.i_cmd_valid   = 1'b0;
    bus_if.i_cmd_write   = 1'b0;
    bus_if.i_cmd_addr    = '0;
    bus_if.i_cmd_wdata   = '0;
    bus_if.i_cmd_wstrb   = '0;
    bus_if.i_rsp_ready   = 1'b0;
    bus_if.m_axi_awready = 1'b0;
    bus_if.m_axi_wready  = 1'b0;
    bus_if.m_axi_bresp   = 2'b00;
    bus_if.m_axi_bvalid  = 1'b0;
    bus_if.m_axi_arready = 1'b0;
    bus_if.m_axi_rdata   = '0;
    bus_if.m_axi_rresp   = 2'b00;
    bus_if.m_axi_rvalid  = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW/8-1:0] wstrb);
    bus_if.i_cmd_valid = 1'b1;
    bus_if.i_cmd_write = wr;
    bus_if.i_cmd_addr  = addr;
    bus_if.i_cmd_wdata = wdata;
    bus_if.i_cmd_wstrb = wstrb;
  endtask

  task automatic chk_all_quiet(input string tag);
    chk({tag, "_awvalid"}, bus_if.m_axi_awvalid, 1'b0);
    chk({tag, "_wvalid"},  bus_if.m_axi_wvalid,  1'b0);
    chk({tag, "_bready"},  bus_if.m_axi_bready,  1'b0);
    chk({tag, "_arvalid"}, bus_if.m_axi_arvalid, 1'b0);
    chk({tag, "_rready"},  bus_if.m_axi_rready,  1'b0);
    chk({tag, "_rspv"},    bus_if.o_rsp_valid,   1'b0);
    chk({tag, "_cmdrdy"},  bus_if.o_cmd_ready,   1'b0);
  endtask

  // Directed sequence
  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_quiet("rst");
    chk("rst_awaddr", bus_if.m_axi_awaddr, 32'h0);
    chk("rst_rdata",  bus_if.o_rsp_rdata,  32'h0);
    chk("rst_state",  dbg_state,           3'd0);
    reset = 1'b0;
    #1;
    chk("rel_cmdrdy", bus_if.o_cmd_ready, 1'b1);

    // ---- Zero-wait write ----
    issue(1'b1, 32'h30, 32'hA5A5_0001, 4'hF);
    bus_if.m_axi_awready = 1'b1;
    bus_if.m_axi_wready  = 1'b1;
    step();                                   // T: accept
    bus_if.i_cmd_valid = 1'b0;
    chk("w1_cmdrdy",  bus_if.o_cmd_ready,   1'b0);
    chk("w1_awvalid", bus_if.m_axi_awvalid, 1'b1);
    chk("w1_wvalid",  bus_if.m_axi_wvalid,  1'b1);
    chk("w1_awaddr",  bus_if.m_axi_awaddr,  32'h30);
    chk("w1_wdata",   bus_if.m_axi_wdata,   32'hA5A5_0001);
    chk("w1_wstrb",   bus_if.m_axi_wstrb,   4'hF);
    chk("w1_awprot",  bus_if.m_axi_awprot,  3'b000);
    bus_if.m_axi_bvalid = 1'b1;
    bus_if.m_axi_bresp  = 2'b00;
    step();                                   // T+1: AW/W handshake
    chk("w1_aw_drop", bus_if.m_axi_awvalid, 1'b0);
    chk("w1_w_drop",  bus_if.m_axi_wvalid,  1'b0);
    chk("w1_bready",  bus_if.m_axi_bready,  1'b1);
    chk("w1_rspv_early", bus_if.o_rsp_valid, 1'b0);
    step();                                   // T+2: B handshake
    bus_if.m_axi_bvalid  = 1'b0;
    bus_if.m_axi_awready = 1'b0;
    bus_if.m_axi_wready  = 1'b0;
    chk("w1_rspv",    bus_if.o_rsp_valid,   1'b1);
    chk("w1_rspwr",   bus_if.o_rsp_write,   1'b1);
    chk("w1_resp",    bus_if.o_rsp_resp,    2'b00);
    chk("w1_tmo",     bus_if.o_rsp_timeout, 1'b0);
    chk("w1_rdata",   bus_if.o_rsp_rdata,   32'h0);
    chk("w1_bready_off", bus_if.m_axi_bready, 1'b0);
    bus_if.i_rsp_ready = 1'b1;
    step();                                   // rsp accept
    bus_if.i_rsp_ready = 1'b0;
    chk("w1_done_rspv",   bus_if.o_rsp_valid, 1'b0);
    chk("w1_done_cmdrdy", bus_if.o_cmd_ready, 1'b1);

    // ---- Write with W accepted 3 cycles before AW ----
    issue(1'b1, 32'h34, 32'h1234_5678, 4'h3);
    bus_if.m_axi_wready = 1'b1;
    step();                                   // accept
    bus_if.i_cmd_valid = 1'b0;
    chk("w2_awvalid", bus_if.m_axi_awvalid, 1'b1);
    chk("w2_wvalid",  bus_if.m_axi_wvalid,  1'b1);
    step();                                   // W handshake
    bus_if.m_axi_wready = 1'b0;
    chk("w2_w_drop",  bus_if.m_axi_wvalid,  1'b0);
    chk("w2_aw_hold1", bus_if.m_axi_awvalid, 1'b1);
    chk("w2_state_req", dbg_state, 3'd1);
    step();
    chk("w2_aw_hold2", bus_if.m_axi_awvalid, 1'b1);
    chk("w2_bready_off", bus_if.m_axi_bready, 1'b0);
    step();
    chk("w2_aw_hold3", bus_if.m_axi_awvalid, 1'b1);
    bus_if.m_axi_awready = 1'b1;
    step();                                   // AW handshake
    bus_if.m_axi_awready = 1'b0;
    chk("w2_aw_drop", bus_if.m_axi_awvalid, 1'b0);
    chk("w2_bready",  bus_if.m_axi_bready,  1'b1);
    bus_if.m_axi_bvalid = 1'b1;
    bus_if.m_axi_bresp  = 2'b01;
    step();                                   // single B
    bus_if.m_axi_bvalid = 1'b0;
    bus_if.m_axi_bresp  = 2'b00;
    chk("w2_rspv",  bus_if.o_rsp_valid, 1'b1);
    chk("w2_resp",  bus_if.o_rsp_resp,  2'b01);
    bus_if.i_rsp_ready = 1'b1;
    step();
    bus_if.i_rsp_ready = 1'b0;
    chk("w2_rspv_off", bus_if.o_rsp_valid, 1'b0);
    step();
    chk("w2_one_rsp", bus_if.o_rsp_valid, 1'b0);
    chk("w2_cmdrdy",  bus_if.o_cmd_ready, 1'b1);

    // ---- Read, R after 5 cycles with SLVERR ----
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    bus_if.m_axi_arready = 1'b1;
    step();                                   // accept
    bus_if.i_cmd_valid = 1'b0;
    chk("r1_arvalid", bus_if.m_axi_arvalid, 1'b1);
    chk("r1_araddr",  bus_if.m_axi_araddr,  32'h10);
    chk("r1_awvalid", bus_if.m_axi_awvalid, 1'b0);
    step();                                   // AR handshake
    bus_if.m_axi_arready = 1'b0;
    chk("r1_ar_drop", bus_if.m_axi_arvalid, 1'b0);
    chk("r1_rready",  bus_if.m_axi_rready,  1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("r1_wait_rspv", bus_if.o_rsp_valid, 1'b0);
    end
    bus_if.m_axi_rvalid = 1'b1;
    bus_if.m_axi_rdata  = 32'hDEAD_BEEF;
    bus_if.m_axi_rresp  = 2'b10;
    step();                                   // R handshake
    bus_if.m_axi_rvalid = 1'b0;
    bus_if.m_axi_rdata  = 32'h0;
    bus_if.m_axi_rresp  = 2'b00;
    chk("r1_rspv",  bus_if.o_rsp_valid,   1'b1);
    chk("r1_rdata", bus_if.o_rsp_rdata,   32'hDEAD_BEEF);
    chk("r1_resp",  bus_if.o_rsp_resp,    2'b10);
    chk("r1_write", bus_if.o_rsp_write,   1'b0);
    chk("r1_tmo",   bus_if.o_rsp_timeout, 1'b0);

    // ---- Response held off for 10 cycles ----
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_rspv",   bus_if.o_rsp_valid, 1'b1);
      chk("hold_rdata",  bus_if.o_rsp_rdata, 32'hDEAD_BEEF);
      chk("hold_resp",   bus_if.o_rsp_resp,  2'b10);
      chk("hold_cmdrdy", bus_if.o_cmd_ready, 1'b0);
    end
    bus_if.i_rsp_ready = 1'b1;
    issue(1'b0, 32'h20, 32'h0, 4'h0);       // not accepted while in RSP
    step();                                   // rsp accept
    bus_if.i_rsp_ready = 1'b0;
    chk("hold_after_rspv",   bus_if.o_rsp_valid,   1'b0);
    chk("hold_after_cmdrdy", bus_if.o_cmd_ready,   1'b1);
    chk("hold_after_ar",     bus_if.m_axi_arvalid, 1'b0);

    // ---- Read that times out (TIMEOUT_CYCLES = 8) ----
    step();                                   // second command accepted
    bus_if.i_cmd_valid = 1'b0;
    chk("to_cmdrdy",  bus_if.o_cmd_ready,   1'b0);
    chk("to_arvalid", bus_if.m_axi_arvalid, 1'b1);
    chk("to_araddr",  bus_if.m_axi_araddr,  32'h20);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("to_wait_rspv", bus_if.o_rsp_valid,   1'b0);
      chk("to_wait_ar",   bus_if.m_axi_arvalid, 1'b1);
    end
    step();                                   // expiry
    chk("to_rspv",    bus_if.o_rsp_valid,   1'b1);
    chk("to_tmo",     bus_if.o_rsp_timeout, 1'b1);
    chk("to_resp",    bus_if.o_rsp_resp,    2'b10);
    chk("to_rdata",   bus_if.o_rsp_rdata,   32'h0);
    chk("to_write",   bus_if.o_rsp_write,   1'b0);
    chk("to_ar_kept", bus_if.m_axi_arvalid, 1'b1);
    chk("to_rready",  bus_if.m_axi_rready,  1'b0);
    bus_if.i_rsp_ready = 1'b1;
    step();                                   // into drain
    bus_if.i_rsp_ready = 1'b0;
    chk("dr_rspv",    bus_if.o_rsp_valid,   1'b0);
    chk("dr_cmdrdy",  bus_if.o_cmd_ready,   1'b0);
    chk("dr_arvalid", bus_if.m_axi_arvalid, 1'b1);
    chk("dr_rready",  bus_if.m_axi_rready,  1'b1);
    chk("dr_state",   dbg_state,            3'd6);
    bus_if.m_axi_arready = 1'b1;
    step();                                   // late AR handshake
    bus_if.m_axi_arready = 1'b0;
    chk("dr_ar_drop", bus_if.m_axi_arvalid, 1'b0);
    chk("dr_cmdrdy2", bus_if.o_cmd_ready,   1'b0);
    bus_if.m_axi_rvalid = 1'b1;
    bus_if.m_axi_rdata  = 32'h5555_AAAA;
    step();                                   // late R discarded
    bus_if.m_axi_rvalid = 1'b0;
    bus_if.m_axi_rdata  = 32'h0;
    chk("dr_end_cmdrdy", bus_if.o_cmd_ready, 1'b1);
    chk("dr_end_rready", bus_if.m_axi_rready, 1'b0);
    chk("dr_end_rspv",   bus_if.o_rsp_valid,  1'b0);
    step();
    chk("dr_no_rsp",     bus_if.o_rsp_valid,  1'b0);

    // ---- Reset while waiting for B ----
    issue(1'b1, 32'h40, 32'h0BAD_F00D, 4'hF);
    bus_if.m_axi_awready = 1'b1;
    bus_if.m_axi_wready  = 1'b1;
    step();                                   // accept
    bus_if.i_cmd_valid = 1'b0;
    step();                                   // AW/W handshake
    bus_if.m_axi_awready = 1'b0;
    bus_if.m_axi_wready  = 1'b0;
    chk("mr_bready_pre", bus_if.m_axi_bready, 1'b1);
    reset = 1'b1;
    #1;
    chk_all_quiet("mr");
    chk("mr_awaddr", bus_if.m_axi_awaddr, 32'h0);
    chk("mr_state",  dbg_state,           3'd0);
    step();
    reset = 1'b0;
    #1;
    chk("mr_rel_cmdrdy", bus_if.o_cmd_ready, 1'b1);
    step();
    chk("mr_idle_cmdrdy", bus_if.o_cmd_ready, 1'b1);
    chk("mr_idle_bready", bus_if.m_axi_bready, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
